fir_mac_scheduler: RTL
======================

FIR_MAC_SCHEDULER -- requirements
Module: fir_mac_scheduler

Interface
REQ-001 SHALL have parameter NTAPS, default 14: number of filter taps (>=2).
REQ-002 SHALL have parameter DW, default 32: signed sample and result width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port h  input  NTAPS  coefficient mask: h[k]=1 means tap k has coefficient 1, else 0.
REQ-006 SHALL have port in_valid  input  1  signal_in carries a new sample.
REQ-007 SHALL have port in_ready  output  1  the block accepts a sample this cycle.
REQ-008 SHALL have port signal_in  input  DW  signed input sample.
REQ-009 SHALL have port out_valid  output  1  filter_out holds a completed result.
REQ-010 SHALL have port out_ready  input  1  the consumer takes the result this cycle.
REQ-011 SHALL have port filter_out  output  DW  signed filter result.
REQ-012 SHALL have port flush  input  1  clears the delay line when idle.
REQ-013 SHALL have port busy  output  1  high in states ACCUM and HOLD.
REQ-014 SHALL have port primed  output  1  high once NTAPS samples have been accepted since reset or flush.

Function
REQ-015 SHALL time-share one accumulator over all taps: one tap per clock, using an NTAPS-entry circular delay line with write pointer wr_ptr.
REQ-016 SHALL implement states IDLE, ACCUM, HOLD; in_ready = (state==IDLE) && !flush.
REQ-017 SHALL, in IDLE on in_valid&&in_ready: write signal_in to line[wr_ptr], snapshot h, clear acc, set tap index k=0, go ACCUM.
REQ-018 SHALL, in ACCUM each cycle: acc += hsnap[k] ? line[(wr_ptr-k) mod NTAPS] : 0; k++; after k=NTAPS-1, load filter_out, assert out_valid, go HOLD.
REQ-019 SHALL give latency NTAPS cycles from the accepting edge to out_valid high; minimum sample period NTAPS+2 cycles.
REQ-020 SHALL, in HOLD, keep out_valid, filter_out stable until out_ready=1; on that edge drop out_valid, advance wr_ptr (NTAPS-1 wraps to 0), go IDLE.
REQ-021 SHALL ignore in_valid outside IDLE; changes to h after acceptance SHALL NOT affect the sample in progress.
REQ-022 SHALL keep acc at DW+$clog2(NTAPS) bits, sign-extending samples; reduction to DW per REQ-029.
REQ-023 SHALL, on flush in IDLE, zero the delay line, wr_ptr and primed counter; flush wins over simultaneous in_valid; flush outside IDLE SHALL be ignored.
REQ-024 SHALL count accepted samples saturating at NTAPS; primed=1 at count NTAPS.

Reset
REQ-025 SHALL, on rst asserted in any state (including mid-ACCUM), go IDLE immediately.
REQ-026 SHALL reset: out_valid=0, filter_out=0, busy=0, primed=0, acc=0, k=0, wr_ptr=0, delay line all 0; in_ready=1 after rst deasserts.
REQ-027 SHALL discard any in-progress sample on reset; no out_valid follows it.

Configuration
REQ-028 SHALL honour macro FIR_MAC_SCHEDULER_SAT_EN.
REQ-029 SHALL, with FIR_MAC_SCHEDULER_SAT_EN defined, clamp acc to [-2^(DW-1), 2^(DW-1)-1] when loading filter_out; without it, filter_out = low DW bits of acc (two's-complement wrap).

Verification
REQ-030 SHALL cover reset: rst pulse -> in_ready=1, out_valid=0, filter_out=0, busy=0, primed=0.
REQ-031 SHALL cover impulse: h=all ones, samples 1,0,0,... -> outputs 1 for the first 14 results, then 0; primed rises after sample 14.
REQ-032 SHALL cover alternating: h[k]=k%2, samples i%2 for i=0..199 -> after priming, results 7 for even i, 0 for odd i.
REQ-033 SHALL cover backpressure: out_ready=0 for 20 cycles in HOLD -> out_valid and filter_out constant, in_ready=0, wr_ptr unchanged.
REQ-034 SHALL cover width: h=all ones, 14 samples of 0x7FFFFFFF -> 14th result 0x7FFFFFFF with SAT_EN, 0xFFFFFFF2 without.
REQ-035 SHALL cover reset mid-operation: rst at k=5 -> IDLE, no out_valid; next impulse yields clean 1 then zeros.

Source files
------------

// File: rtl/fir_mac_scheduler.sv
// Time-shared FIR filter for 0/1 coefficient masks. A single accumulator walks all
// NTAPS taps of a circular delay line, one tap per clock. Each result is held until
// the consumer takes it.
// Optional build macro FIR_MAC_SCHEDULER_SAT_EN: when it is defined, the accumulator
// is clamped to the DW-bit signed range as the result is loaded. When it is not
// defined, the result is the low DW bits of the accumulator, so it wraps.
module fir_mac_scheduler #(
    parameter int unsigned NTAPS = 14,
    parameter int unsigned DW    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NTAPS-1:0] h,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    signal_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    filter_out,
    input  logic             flush,
    output logic             busy,
    output logic             primed
);
    localparam int unsigned PW = $clog2(NTAPS);
    localparam int unsigned AW = DW + PW;
    localparam int unsigned CW = $clog2(NTAPS + 1);
    localparam logic [PW-1:0] LastIdx  = PW'(NTAPS - 1);
    localparam logic [PW-1:0] NtapsMod = PW'(NTAPS);
    localparam logic [CW-1:0] FullCnt  = CW'(NTAPS);

    typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

    state_e               state_q, state_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        k_q, k_d;
    logic [NTAPS-1:0]     hsnap_q, hsnap_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [DW-1:0]        out_q, out_d;
    logic                 out_valid_q, out_valid_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DW-1:0]        line_q [NTAPS];

    logic                 line_we;
    logic                 line_clr;
    logic [PW-1:0]        rd_idx;
    logic [DW-1:0]        tap_sample;
    logic signed [AW-1:0] tap_term;
    logic signed [AW-1:0] acc_sum;
    logic [DW-1:0]        result;

`ifdef FIR_MAC_SCHEDULER_SAT_EN
    localparam logic signed [AW-1:0] MaxVal = $signed({{(PW + 1){1'b0}}, {(DW - 1){1'b1}}});
    localparam logic signed [AW-1:0] MinVal = $signed({{(PW + 1){1'b1}}, {(DW - 1){1'b0}}});
`endif

    // Tap read address (wr_ptr - k) mod NTAPS, then the masked and sign-extended term
    always_comb begin
        rd_idx = wr_ptr_q - k_q;
        if (wr_ptr_q < k_q) begin
            rd_idx = wr_ptr_q - k_q + NtapsMod;
        end
        tap_sample = line_q[rd_idx];
        tap_term   = '0;
        if (hsnap_q[k_q]) begin
            tap_term = $signed({{PW{tap_sample[DW-1]}}, tap_sample});
        end
        acc_sum = acc_q + tap_term;
    end

    // Reduce the full-width sum to DW bits, either by clamping or by wrapping
    always_comb begin
`ifdef FIR_MAC_SCHEDULER_SAT_EN
        result = acc_sum[DW-1:0];
        if (acc_sum > MaxVal) begin
            result = {1'b0, {(DW - 1){1'b1}}};
        end else if (acc_sum < MinVal) begin
            result = {1'b1, {(DW - 1){1'b0}}};
        end
`else
        result = acc_sum[DW-1:0];
`endif
    end

    // Next-state logic for the FSM and the datapath registers
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        k_d         = k_q;
        hsnap_d     = hsnap_q;
        acc_d       = acc_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
        line_we     = 1'b0;
        line_clr    = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Flush takes priority over a sample offered in the same cycle
                if (flush) begin
                    line_clr = 1'b1;
                    wr_ptr_d = '0;
                    cnt_d    = '0;
                end else if (in_valid) begin
                    line_we = 1'b1;
                    hsnap_d = h;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = StAccum;
                    if (cnt_q != FullCnt) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            StAccum: begin
                acc_d = acc_sum;
                if (k_q == LastIdx) begin
                    out_d       = result;
                    out_valid_d = 1'b1;
                    state_d     = StHold;
                end else begin
                    k_d = k_q + PW'(1);
                end
            end
            StHold: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    wr_ptr_d    = (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + PW'(1);
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            k_q         <= '0;
            hsnap_q     <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            k_q         <= k_d;
            hsnap_q     <= hsnap_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    // Circular delay line: cleared on reset or flush, written on sample acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                line_q[i] <= '0;
            end
        end else if (line_clr) begin
            for (int i = 0; i < NTAPS; i++) begin
                line_q[i] <= '0;
            end
        end else if (line_we) begin
            line_q[wr_ptr_q] <= signal_in;
        end
    end

    assign in_ready   = (state_q == StIdle) && !flush;
    assign busy       = (state_q != StIdle);
    assign primed     = (cnt_q == FullCnt);
    assign out_valid  = out_valid_q;
    assign filter_out = out_q;

endmodule
